// File: rtl/system_commands_pkg.sv
// Shared opcodes, ALU operand addresses and state encodings for the command sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package system_commands_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] CMD_REG_WRITE       = 8'hAA;
    localparam logic [7:0] CMD_REG_READ        = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPERANDS    = 8'hCC;
    localparam logic [7:0] CMD_ALU_NO_OPERANDS = 8'hDD;

    // The ALU reads its operands from these two register file entries
    localparam int unsigned ALU_OPERAND_A_ADDRESS = 0;
    localparam int unsigned ALU_OPERAND_B_ADDRESS = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUNC,
        ST_ALU_WAIT,
        ST_SEND
    } sequencer_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_PUSH,
        TX_WAIT_BUSY_HIGH,
        TX_WAIT_BUSY_LOW
    } sender_state_t;

endpackage

// File: rtl/command_sequencer_if.sv
// Bus bundle between the command sequencer and its RX, register file, ALU and TX neighbours.
// Latency: none (wires only).
// Backpressure: only tx_busy; every other transfer is a one-cycle strobe or qualifier.
// Modports: master = command sequencer side, slave = peripheral side.
interface command_sequencer_if #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int ALU_FUNCTION_WIDTH  = 4
);
    localparam int ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    logic [DATA_WIDTH-1:0]         rx_data;
    logic                          rx_data_valid;
    logic [ADDRESS_WIDTH-1:0]      register_file_address;
    logic                          register_file_write_enable;
    logic [DATA_WIDTH-1:0]         register_file_write_data;
    logic                          register_file_read_enable;
    logic [DATA_WIDTH-1:0]         register_file_read_data;
    logic                          register_file_read_data_valid;
    logic                          alu_enable;
    logic [ALU_FUNCTION_WIDTH-1:0] alu_function;
    logic                          alu_clock_gate_enable;
    logic [2*DATA_WIDTH-1:0]       alu_result;
    logic                          alu_result_valid;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_data_valid;
    logic                          tx_busy;
    logic                          command_error;

    modport master (
        input  rx_data, rx_data_valid, register_file_read_data, register_file_read_data_valid,
               alu_result, alu_result_valid, tx_busy,
        output register_file_address, register_file_write_enable, register_file_write_data,
               register_file_read_enable, alu_enable, alu_function, alu_clock_gate_enable,
               tx_data, tx_data_valid, command_error
    );

    modport slave (
        output rx_data, rx_data_valid, register_file_read_data, register_file_read_data_valid,
               alu_result, alu_result_valid, tx_busy,
        input  register_file_address, register_file_write_enable, register_file_write_data,
               register_file_read_enable, alu_enable, alu_function, alu_clock_gate_enable,
               tx_data, tx_data_valid, command_error
    );

endinterface

// File: rtl/command_sequencer_response_sender.sv
// Holds one or two response bytes and pushes them low byte first to the TX path.
// Latency: first push the cycle after load if tx_busy=0; done pulses one cycle after the last busy fall.
// Backpressure: each push waits for tx_busy=0, then for a full tx_busy 1->0 cycle before the next.
// Ports: clk/rst_n, load + two_bytes + load_data from the parent, tx_busy in, tx_data/tx_data_valid out, done out.
module response_sender
    import system_commands_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    load_two_bytes,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_data_valid,
    output logic                    done
);
    sender_state_t           state;
    logic [2*DATA_WIDTH-1:0] buffer;
    logic                    second_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= TX_IDLE;
            buffer         <= '0;
            second_pending <= 1'b0;
            tx_data        <= '0;
            tx_data_valid  <= 1'b0;
            done           <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            done          <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (load) begin
                        buffer         <= load_data;
                        second_pending <= load_two_bytes;
                        state          <= TX_PUSH;
                    end
                end
                TX_PUSH: begin
                    if (!tx_busy) begin
                        tx_data       <= buffer[DATA_WIDTH-1:0];
                        tx_data_valid <= 1'b1;
                        state         <= TX_WAIT_BUSY_HIGH;
                    end
                end
                // The transmitter must acknowledge with a busy period before the byte counts as taken
                TX_WAIT_BUSY_HIGH: begin
                    if (tx_busy) begin
                        state <= TX_WAIT_BUSY_LOW;
                    end
                end
                TX_WAIT_BUSY_LOW: begin
                    if (!tx_busy) begin
                        if (second_pending) begin
                            buffer         <= {{DATA_WIDTH{1'b0}}, buffer[2*DATA_WIDTH-1:DATA_WIDTH]};
                            second_pending <= 1'b0;
                            state          <= TX_PUSH;
                        end else begin
                            done  <= 1'b1;
                            state <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/command_sequencer.sv
// Decodes RX byte frames (AA write, BB read, CC ALU with operands, DD ALU) into register file / ALU ops and TX responses.
// Latency: write strobe and read strobe 1 cycle after the last needed byte; alu_enable 1 cycle after the function byte.
// Backpressure: none on RX (bytes arriving while busy are dropped with command_error); TX paced by tx_busy.
// Ports: reference_clk, reset (async active-low), bus (command_sequencer_if.master).
// Build option: define COMMAND_SEQUENCER_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module command_sequencer
    import system_commands_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int ALU_FUNCTION_WIDTH  = 4
`ifdef COMMAND_SEQUENCER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES      = 65535
`endif
) (
    input logic                 reference_clk,
    input logic                 reset,
    command_sequencer_if.master bus
);
    localparam int ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    sequencer_state_t        state;
    logic                    sender_load;
    logic                    sender_two_bytes;
    logic [2*DATA_WIDTH-1:0] sender_data;
    logic                    sender_done;
    logic                    timeout_hit;

    response_sender #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_response_sender (
        .clk           (reference_clk),
        .rst_n         (reset),
        .load          (sender_load),
        .load_two_bytes(sender_two_bytes),
        .load_data     (sender_data),
        .tx_busy       (bus.tx_busy),
        .tx_data       (bus.tx_data),
        .tx_data_valid (bus.tx_data_valid),
        .done          (sender_done)
    );

`ifdef COMMAND_SEQUENCER_TIMEOUT_EN
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic                   timed_state;
    logic [TIMER_WIDTH-1:0] idle_cycles;

    // Only states that are waiting for more frame bytes can time out
    assign timed_state = (state inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_OP_A, ST_OP_B, ST_ALU_FUNC});
    assign timeout_hit = timed_state && !bus.rx_data_valid &&
                         (idle_cycles == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            idle_cycles <= '0;
        end else if (!timed_state || bus.rx_data_valid || timeout_hit) begin
            idle_cycles <= '0;
        end else begin
            idle_cycles <= idle_cycles + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge reference_clk or negedge reset) begin
        if (!reset) begin
            state                          <= ST_IDLE;
            bus.register_file_address      <= '0;
            bus.register_file_write_enable <= 1'b0;
            bus.register_file_write_data   <= '0;
            bus.register_file_read_enable  <= 1'b0;
            bus.alu_enable                 <= 1'b0;
            bus.alu_function               <= '0;
            bus.alu_clock_gate_enable      <= 1'b0;
            bus.command_error              <= 1'b0;
            sender_load                    <= 1'b0;
            sender_two_bytes               <= 1'b0;
            sender_data                    <= '0;
        end else begin
            bus.register_file_write_enable <= 1'b0;
            bus.register_file_read_enable  <= 1'b0;
            bus.alu_enable                 <= 1'b0;
            bus.command_error              <= 1'b0;
            sender_load                    <= 1'b0;

            if (timeout_hit) begin
                // Abandon the partial frame without issuing any strobe
                state                     <= ST_IDLE;
                bus.command_error         <= 1'b1;
                bus.alu_clock_gate_enable <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_data_valid) begin
                            case (bus.rx_data)
                                DATA_WIDTH'(CMD_REG_WRITE):    state <= ST_WR_ADDR;
                                DATA_WIDTH'(CMD_REG_READ):     state <= ST_RD_ADDR;
                                DATA_WIDTH'(CMD_ALU_OPERANDS): state <= ST_OP_A;
                                DATA_WIDTH'(CMD_ALU_NO_OPERANDS): begin
                                    // Ungate the ALU clock ahead of the function byte
                                    bus.alu_clock_gate_enable <= 1'b1;
                                    state                     <= ST_ALU_FUNC;
                                end
                                default: bus.command_error <= 1'b1;
                            endcase
                        end
                    end
                    ST_WR_ADDR: begin
                        if (bus.rx_data_valid) begin
                            bus.register_file_address <= bus.rx_data[ADDRESS_WIDTH-1:0];
                            state                     <= ST_WR_DATA;
                        end
                    end
                    ST_WR_DATA: begin
                        if (bus.rx_data_valid) begin
                            bus.register_file_write_data   <= bus.rx_data;
                            bus.register_file_write_enable <= 1'b1;
                            state                          <= ST_IDLE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (bus.rx_data_valid) begin
                            bus.register_file_address     <= bus.rx_data[ADDRESS_WIDTH-1:0];
                            bus.register_file_read_enable <= 1'b1;
                            state                         <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        bus.command_error <= bus.rx_data_valid;
                        if (bus.register_file_read_data_valid) begin
                            sender_data      <= {{DATA_WIDTH{1'b0}}, bus.register_file_read_data};
                            sender_two_bytes <= 1'b0;
                            sender_load      <= 1'b1;
                            state            <= ST_SEND;
                        end
                    end
                    ST_OP_A: begin
                        if (bus.rx_data_valid) begin
                            bus.register_file_address      <= ADDRESS_WIDTH'(ALU_OPERAND_A_ADDRESS);
                            bus.register_file_write_data   <= bus.rx_data;
                            bus.register_file_write_enable <= 1'b1;
                            state                          <= ST_OP_B;
                        end
                    end
                    ST_OP_B: begin
                        if (bus.rx_data_valid) begin
                            bus.register_file_address      <= ADDRESS_WIDTH'(ALU_OPERAND_B_ADDRESS);
                            bus.register_file_write_data   <= bus.rx_data;
                            bus.register_file_write_enable <= 1'b1;
                            bus.alu_clock_gate_enable      <= 1'b1;
                            state                          <= ST_ALU_FUNC;
                        end
                    end
                    ST_ALU_FUNC: begin
                        if (bus.rx_data_valid) begin
                            bus.alu_function <= bus.rx_data[ALU_FUNCTION_WIDTH-1:0];
                            bus.alu_enable   <= 1'b1;
                            state            <= ST_ALU_WAIT;
                        end
                    end
                    ST_ALU_WAIT: begin
                        bus.command_error <= bus.rx_data_valid;
                        if (bus.alu_result_valid) begin
                            bus.alu_clock_gate_enable <= 1'b0;
                            sender_data               <= bus.alu_result;
                            sender_two_bytes          <= 1'b1;
                            sender_load               <= 1'b1;
                            state                     <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        bus.command_error <= bus.rx_data_valid;
                        if (sender_done) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/command_sequencer.md
Name: command_sequencer

Overview:
- Reference-clock-domain controller that turns synchronized UART RX bytes into register-file and ALU operations, then returns results through the UART TX path.
- Frame opcodes:
  - 0xAA: register write, with address and data.
  - 0xBB: register read, with address.
  - 0xCC: ALU operation with operands A and B, plus function.
  - 0xDD: ALU operation on the stored operands, plus function.
- Sits between the RX data synchronizer, the register file, the ALU (plus its clock gate) and the TX-side FIFO/synchronizer.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX/register data
REGISTER_FILE_DEPTH, 16, register file entries; ADDRESS_WIDTH = $clog2(REGISTER_FILE_DEPTH)
ALU_FUNCTION_WIDTH, 4, width of ALU function code
TIMEOUT_CYCLES, 65535, idle reference_clk cycles before a partial frame is aborted (used only with the optional feature)

Ports:
reference_clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  DATA_WIDTH  synchronized received byte
rx_data_valid  input  1  one-cycle pulse per received byte
register_file_address  output  ADDRESS_WIDTH  register file address
register_file_write_enable  output  1  one-cycle write strobe
register_file_write_data  output  DATA_WIDTH  write data
register_file_read_enable  output  1  one-cycle read strobe
register_file_read_data  input  DATA_WIDTH  read data
register_file_read_data_valid  input  1  read data qualifier
alu_enable  output  1  one-cycle ALU start
alu_function  output  ALU_FUNCTION_WIDTH  ALU operation code
alu_clock_gate_enable  output  1  ungates the ALU clock
alu_result  input  2*DATA_WIDTH  ALU result
alu_result_valid  input  1  ALU result qualifier
tx_data  output  DATA_WIDTH  byte to transmit
tx_data_valid  output  1  one-cycle push of tx_data
tx_busy  input  1  synchronized transmitter busy
command_error  output  1  one-cycle error pulse

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all strobes, valids, gate enable and command_error = 0; all data and address outputs = 0.
- A byte is consumed only on a cycle with rx_data_valid=1.
- States and transitions:
  - IDLE: 0xAA → WR_ADDR; 0xBB → RD_ADDR; 0xCC → OP_A; 0xDD → ALU_FUNC; any other byte → command_error pulse, stay in IDLE.
  - WR_ADDR: latch address (low ADDRESS_WIDTH bits; upper bits ignored) → WR_DATA.
  - WR_DATA: next cycle write_enable=1 with latched address and data → IDLE.
  - RD_ADDR: latch address; next cycle read_enable=1 → RD_WAIT.
  - RD_WAIT: on read_data_valid, capture the byte → SEND (1 byte).
  - OP_A: write the byte to address 0 → OP_B.
  - OP_B: write the byte to address 1 → ALU_FUNC.
  - ALU_FUNC: latch the low ALU_FUNCTION_WIDTH bits; assert gate enable; alu_enable=1 for one cycle → ALU_WAIT.
  - ALU_WAIT: on alu_result_valid, capture 16 bits; drop gate enable → SEND (2 bytes: low byte, then high byte).
- Gate enable rises one cycle before alu_enable and stays high until alu_result_valid.
- SEND handshake, per byte:
  - When tx_busy=0, pulse tx_data_valid for one cycle.
  - Wait for tx_busy=1, then for tx_busy=0.
  - After the last byte → IDLE.
- Latency: write strobe 1 cycle after the data byte; alu_enable 1 cycle after the function byte.
- RX bytes arriving in RD_WAIT, ALU_WAIT or SEND: dropped, command_error pulse, state unchanged.
- Reset asserted mid-frame or mid-send: immediate return to IDLE; no partial write is issued.

Optional Feature:
- Macro: COMMAND_SEQUENCER_TIMEOUT_EN.
- When defined:
  - A counter reloads on each consumed byte and runs in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUNC.
  - After TIMEOUT_CYCLES cycles with no byte: command_error pulse, return to IDLE, no strobes issued.
- When undefined: no counter; partial frames wait indefinitely.

Decomposition:
- Package system_commands_pkg holds:
  - opcode constants: CMD_REG_WRITE=0xAA, CMD_REG_READ=0xBB, CMD_ALU_OPERANDS=0xCC, CMD_ALU_NO_OPERANDS=0xDD;
  - ALU operand addresses 0 and 1;
  - the state enumeration.
- One sub-module: response_sender. It holds up to two bytes and runs the tx_busy handshake; the parent loads it with the byte count and data.

Test Plan:
- AA,05,3C → write strobe, address=5, data=0x3C; no TX; back in IDLE.
- BB,05 after the write above → read_enable at address 5; stub returns 0x3C → tx_data=0x3C single push; next push only after a tx_busy 1→0 cycle.
- CC,0A,14,00 (add) → writes 0x0A@0 and 0x14@1; alu_enable with function 0; gate high until result 0x001E; TX 0x1E then 0x00.
- DD,02 with result stub 0x1234 → TX 0x34 then 0x12; gate enable pulses around the operation.
- Byte 0x7E in IDLE → command_error pulse; a byte during RD_WAIT → dropped plus error; reset asserted after AA,05 → no write strobe, IDLE.
- Timeout build with TIMEOUT_CYCLES=100, stimulus AA then silence → error at cycle 100, IDLE; the next frame AA,01,FF works.
